// File: rtl/conv_addr_gen.sv
`default_nettype none
// ============================================================================
// conv_addr_gen : sliding-window activation, weight and bias SRAM address
//                 sequencer for one convolution layer (preload, sweep, done).
// Revision      : 1.0
// ============================================================================
module conv_addr_gen #(
  parameter int ADDR_W  = 6,
  parameter int WADDR_W = 10,
  parameter int BADDR_W = 6,
  parameter int DIM_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                grp_sel,
  input  logic [DIM_W-1:0]    out_w,
  input  logic [DIM_W-1:0]    out_h,
  input  logic [DIM_W-1:0]    n_filt,
  input  logic [ADDR_W-1:0]   row_stride,
  input  logic [DIM_W-1:0]    wload_len,
  input  logic                stall,
  output logic [4*ADDR_W-1:0] sram_raddr_a,
  output logic [4*ADDR_W-1:0] sram_raddr_b,
  output logic [WADDR_W-1:0]  sram_raddr_weight,
  output logic [BADDR_W-1:0]  sram_raddr_bias,
  output logic                win_valid,
  output logic                load_done,
  output logic                layer_done,
  output logic                busy
);

  localparam int PW = DIM_W + ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD_W = 2'd1,
    S_CONV   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                grp_q, grp_d;
  logic [DIM_W-1:0]    w_q, w_d, h_q, h_d, nf_q, nf_d, wlen_q, wlen_d;
  logic [ADDR_W-1:0]   stride_q, stride_d;
  logic [DIM_W-1:0]    cnt_q, cnt_d, r_q, r_d, c_q, c_d, f_q, f_d;
  logic [WADDR_W-1:0]  wptr_q, wptr_d;
  logic [BADDR_W-1:0]  bptr_q, bptr_d;
  logic [4*ADDR_W-1:0] addr_a_q, addr_b_q, win_addr_d;
  logic                win_q, ld_q, lyd_q;

  // Banks 0/1 hold the even/odd rows starting one row ahead of banks 2/3;
  // within a bank pair the same (c+1)>>1 / c>>1 split picks the column word.
  function automatic logic [4*ADDR_W-1:0] win_addr(
    input logic [DIM_W-1:0]  r,
    input logic [DIM_W-1:0]  c,
    input logic [ADDR_W-1:0] stride
  );
    logic [DIM_W:0]    r_hi, r_lo, c_hi, c_lo;
    logic [PW-1:0]     p01, p23;
    logic [ADDR_W-1:0] base01, base23;
    r_hi   = ({1'b0, r} + (DIM_W+1)'(1)) >> 1;
    r_lo   = {1'b0, r} >> 1;
    c_hi   = ({1'b0, c} + (DIM_W+1)'(1)) >> 1;
    c_lo   = {1'b0, c} >> 1;
    p01    = PW'(r_hi) * PW'(stride);
    p23    = PW'(r_lo) * PW'(stride);
    base01 = p01[ADDR_W-1:0];
    base23 = p23[ADDR_W-1:0];
    return {base23 + ADDR_W'(c_lo), base23 + ADDR_W'(c_hi),
            base01 + ADDR_W'(c_lo), base01 + ADDR_W'(c_hi)};
  endfunction

  always_comb begin
    state_d  = state_q;
    grp_d    = grp_q;
    w_d      = w_q;
    h_d      = h_q;
    nf_d     = nf_q;
    wlen_d   = wlen_q;
    stride_d = stride_q;
    cnt_d    = cnt_q;
    r_d      = r_q;
    c_d      = c_q;
    f_d      = f_q;
    wptr_d   = wptr_q;
    bptr_d   = bptr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          grp_d    = grp_sel;
          w_d      = out_w;
          h_d      = out_h;
          nf_d     = n_filt;
          wlen_d   = wload_len;
          stride_d = row_stride;
          cnt_d    = '0;
          r_d      = '0;
          c_d      = '0;
          f_d      = '0;
          if (out_w == '0 || out_h == '0 || n_filt == '0)
            state_d = S_DONE;
          else if (wload_len != '0)
            state_d = S_LOAD_W;
          else
            state_d = S_CONV;
        end
      end
      S_LOAD_W: begin
        if (!stall) begin
          if (cnt_q == wlen_q - DIM_W'(1)) begin
            cnt_d   = '0;
            state_d = S_CONV;
          end else begin
            cnt_d  = cnt_q + DIM_W'(1);
            wptr_d = wptr_q + WADDR_W'(1);
          end
        end
      end
      S_CONV: begin
        if (!stall) begin
          if (c_q == w_q - DIM_W'(1)) begin
            c_d = '0;
            if (r_q == h_q - DIM_W'(1)) begin
              // End of one filter sweep: advance to the next filter's data.
              r_d    = '0;
              f_d    = f_q + DIM_W'(1);
              wptr_d = wptr_q + WADDR_W'(1);
              bptr_d = bptr_q + BADDR_W'(1);
              if (f_q == nf_q - DIM_W'(1))
                state_d = S_DONE;
            end else begin
              r_d = r_q + DIM_W'(1);
            end
          end else begin
            c_d = c_q + DIM_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign win_addr_d = win_addr(r_d, c_d, stride_d);

  // Outputs are registered from the next-state values so they line up with
  // the state they describe; a stall keeps every _d equal to its _q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      grp_q    <= 1'b0;
      w_q      <= '0;
      h_q      <= '0;
      nf_q     <= '0;
      wlen_q   <= '0;
      stride_q <= '0;
      cnt_q    <= '0;
      r_q      <= '0;
      c_q      <= '0;
      f_q      <= '0;
      wptr_q   <= '0;
      bptr_q   <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      win_q    <= 1'b0;
      ld_q     <= 1'b0;
      lyd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grp_q    <= grp_d;
      w_q      <= w_d;
      h_q      <= h_d;
      nf_q     <= nf_d;
      wlen_q   <= wlen_d;
      stride_q <= stride_d;
      cnt_q    <= cnt_d;
      r_q      <= r_d;
      c_q      <= c_d;
      f_q      <= f_d;
      wptr_q   <= wptr_d;
      bptr_q   <= bptr_d;
      addr_a_q <= (state_d == S_CONV && !grp_d) ? win_addr_d : '0;
      addr_b_q <= (state_d == S_CONV &&  grp_d) ? win_addr_d : '0;
      win_q    <= (state_d == S_CONV);
      ld_q     <= (state_d == S_LOAD_W) && (cnt_d == wlen_d - DIM_W'(1));
      lyd_q    <= (state_d == S_DONE);
    end
  end

  assign sram_raddr_a      = addr_a_q;
  assign sram_raddr_b      = addr_b_q;
  assign sram_raddr_weight = wptr_q;
  assign sram_raddr_bias   = bptr_q;
  assign win_valid         = win_q;
  assign load_done         = ld_q;
  assign layer_done        = lyd_q;
  assign busy              = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_conv_addr_gen.sv
`default_nettype none
// ============================================================================
// tb_conv_addr_gen : directed-vector bench for conv_addr_gen.
// Revision         : 1.0
// ============================================================================
module tb_conv_addr_gen;

  logic        clk = 1'b0;
  logic        rst_n, start, grp_sel, stall;
  logic [3:0]  out_w, out_h, n_filt, wload_len;
  logic [5:0]  row_stride;
  logic [23:0] sram_raddr_a, sram_raddr_b;
  logic [9:0]  sram_raddr_weight;
  logic [5:0]  sram_raddr_bias;
  logic        win_valid, load_done, layer_done, busy;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  conv_addr_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .grp_sel(grp_sel),
    .out_w(out_w), .out_h(out_h), .n_filt(n_filt), .row_stride(row_stride),
    .wload_len(wload_len), .stall(stall),
    .sram_raddr_a(sram_raddr_a), .sram_raddr_b(sram_raddr_b),
    .sram_raddr_weight(sram_raddr_weight), .sram_raddr_bias(sram_raddr_bias),
    .win_valid(win_valid), .load_done(load_done), .layer_done(layer_done),
    .busy(busy)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cfg(input logic g, input logic [3:0] w, input logic [3:0] h,
                     input logic [3:0] n, input logic [5:0] s, input logic [3:0] wl);
    grp_sel = g; out_w = w; out_h = h; n_filt = n; row_stride = s; wload_len = wl;
  endtask

  task automatic start_layer();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; stall = 1'b0;
    cfg(1'b0, 4'd2, 4'd2, 4'd1, 6'd6, 4'd0);
    tick(); tick();
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy got=%0h exp=0", busy); end
    vecs++; if ({sram_raddr_a, sram_raddr_b} !== 48'd0) begin errs++; $display("FAIL rst_addr got=%h exp=0", {sram_raddr_a, sram_raddr_b}); end
    vecs++; if ({sram_raddr_weight, sram_raddr_bias} !== 16'd0) begin errs++; $display("FAIL rst_ptr got=%h exp=0", {sram_raddr_weight, sram_raddr_bias}); end
    vecs++; if ({win_valid, load_done, layer_done} !== 3'b000) begin errs++; $display("FAIL rst_flags got=%b exp=000", {win_valid, load_done, layer_done}); end
    rst_n = 1'b1; start = 1'b0;
    tick();
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_start_ignored busy got=%0h exp=0", busy); end
  endtask

  task automatic test_load_sweep();
    logic [23:0] exp_a [4];
    exp_a[0] = {6'd0, 6'd0, 6'd0, 6'd0};
    exp_a[1] = {6'd0, 6'd1, 6'd0, 6'd1};
    exp_a[2] = {6'd0, 6'd0, 6'd6, 6'd6};
    exp_a[3] = {6'd0, 6'd1, 6'd6, 6'd7};
    cfg(1'b0, 4'd2, 4'd2, 4'd2, 6'd6, 4'd4);
    start_layer();
    for (int i = 0; i < 4; i++) begin
      vecs++; if (sram_raddr_weight !== 10'(i)) begin errs++; $display("FAIL load_weight[%0d] got=%0d exp=%0d", i, sram_raddr_weight, i); end
      vecs++; if (load_done !== (i == 3)) begin errs++; $display("FAIL load_done[%0d] got=%0b exp=%0b", i, load_done, (i == 3)); end
      vecs++; if (win_valid !== 1'b0) begin errs++; $display("FAIL load_winvalid[%0d] got=%0b exp=0", i, win_valid); end
      tick();
    end
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 4; k++) begin
        vecs++; if (win_valid !== 1'b1) begin errs++; $display("FAIL sweep_valid[%0d,%0d] got=%0b exp=1", f, k, win_valid); end
        vecs++; if (sram_raddr_a !== exp_a[k]) begin errs++; $display("FAIL sweep_a[%0d,%0d] got=%h exp=%h", f, k, sram_raddr_a, exp_a[k]); end
        vecs++; if (sram_raddr_b !== 24'd0) begin errs++; $display("FAIL sweep_b[%0d,%0d] got=%h exp=0", f, k, sram_raddr_b); end
        vecs++; if (sram_raddr_weight !== 10'(3 + f)) begin errs++; $display("FAIL sweep_weight[%0d,%0d] got=%0d exp=%0d", f, k, sram_raddr_weight, 3 + f); end
        vecs++; if (sram_raddr_bias !== 6'(f)) begin errs++; $display("FAIL sweep_bias[%0d,%0d] got=%0d exp=%0d", f, k, sram_raddr_bias, f); end
        tick();
      end
    end
    vecs++; if ({layer_done, win_valid, busy} !== 3'b101) begin errs++; $display("FAIL done_flags got=%b exp=101", {layer_done, win_valid, busy}); end
    vecs++; if ({sram_raddr_weight, sram_raddr_bias} !== {10'd5, 6'd2}) begin errs++; $display("FAIL done_ptr got=%0d/%0d exp=5/2", sram_raddr_weight, sram_raddr_bias); end
    vecs++; if (sram_raddr_a !== 24'd0) begin errs++; $display("FAIL done_addr got=%h exp=0", sram_raddr_a); end
    tick();
    vecs++; if ({busy, layer_done} !== 2'b00) begin errs++; $display("FAIL idle_after_done got=%b exp=00", {busy, layer_done}); end
  endtask

  task automatic test_group_a();
    int  n;
    logic seen;
    cfg(1'b0, 4'd6, 4'd6, 4'd1, 6'd6, 4'd0);
    start_layer();
    vecs++; if ({win_valid, load_done} !== 2'b10) begin errs++; $display("FAIL ga_first got=%b exp=10", {win_valid, load_done}); end
    repeat (9) tick();
    vecs++; if (sram_raddr_a !== {6'd1, 6'd2, 6'd7, 6'd8}) begin errs++; $display("FAIL ga_r1c3 got=%h exp=%h", sram_raddr_a, {6'd1, 6'd2, 6'd7, 6'd8}); end
    vecs++; if (sram_raddr_b !== 24'd0) begin errs++; $display("FAIL ga_b_zero got=%h exp=0", sram_raddr_b); end
    // start with different config while busy must be ignored
    start = 1'b1; grp_sel = 1'b1; out_w = 4'd2;
    tick();
    start = 1'b0;
    vecs++; if (sram_raddr_a !== {6'd2, 6'd2, 6'd8, 6'd8}) begin errs++; $display("FAIL ga_r1c4 got=%h exp=%h", sram_raddr_a, {6'd2, 6'd2, 6'd8, 6'd8}); end
    n = 0; seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (layer_done) begin seen = 1'b1; break; end
      if (win_valid) n++;
    end
    vecs++; if (seen !== 1'b1) begin errs++; $display("FAIL ga_done_timeout got=%0b exp=1", seen); end
    vecs++; if (n != 25) begin errs++; $display("FAIL ga_remaining got=%0d exp=25", n); end
    vecs++; if ({sram_raddr_weight, sram_raddr_bias} !== {10'd6, 6'd3}) begin errs++; $display("FAIL ga_ptr got=%0d/%0d exp=6/3", sram_raddr_weight, sram_raddr_bias); end
    tick();
  endtask

  task automatic test_group_b();
    int  n;
    logic seen;
    cfg(1'b1, 4'd5, 4'd5, 4'd2, 6'd6, 4'd0);
    start_layer();
    repeat (24) tick();
    vecs++; if (sram_raddr_b !== {6'd14, 6'd14, 6'd14, 6'd14}) begin errs++; $display("FAIL gb_last got=%h exp=%h", sram_raddr_b, {6'd14, 6'd14, 6'd14, 6'd14}); end
    vecs++; if (sram_raddr_a !== 24'd0) begin errs++; $display("FAIL gb_a_zero got=%h exp=0", sram_raddr_a); end
    vecs++; if (sram_raddr_weight !== 10'd6) begin errs++; $display("FAIL gb_weight0 got=%0d exp=6", sram_raddr_weight); end
    tick();
    vecs++; if ({win_valid, sram_raddr_b} !== {1'b1, 24'd0}) begin errs++; $display("FAIL gb_wrap got=%b/%h exp=1/0", win_valid, sram_raddr_b); end
    vecs++; if ({sram_raddr_weight, sram_raddr_bias} !== {10'd7, 6'd4}) begin errs++; $display("FAIL gb_ptr1 got=%0d/%0d exp=7/4", sram_raddr_weight, sram_raddr_bias); end
    n = 0; seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (layer_done) begin seen = 1'b1; break; end
      if (win_valid) n++;
    end
    vecs++; if (seen !== 1'b1) begin errs++; $display("FAIL gb_done_timeout got=%0b exp=1", seen); end
    vecs++; if (n != 24) begin errs++; $display("FAIL gb_remaining got=%0d exp=24", n); end
    vecs++; if ({sram_raddr_weight, sram_raddr_bias} !== {10'd8, 6'd5}) begin errs++; $display("FAIL gb_ptr got=%0d/%0d exp=8/5", sram_raddr_weight, sram_raddr_bias); end
    tick();
  endtask

  task automatic test_stall();
    cfg(1'b0, 4'd3, 4'd2, 4'd1, 6'd4, 4'd2);
    start_layer();
    vecs++; if ({sram_raddr_weight, load_done} !== {10'd8, 1'b0}) begin errs++; $display("FAIL st_load1 got=%0d/%0b exp=8/0", sram_raddr_weight, load_done); end
    tick();
    vecs++; if ({sram_raddr_weight, load_done} !== {10'd9, 1'b1}) begin errs++; $display("FAIL st_load2 got=%0d/%0b exp=9/1", sram_raddr_weight, load_done); end
    tick();
    repeat (4) tick();
    vecs++; if (sram_raddr_a !== {6'd0, 6'd1, 6'd4, 6'd5}) begin errs++; $display("FAIL st_pos4 got=%h exp=%h", sram_raddr_a, {6'd0, 6'd1, 6'd4, 6'd5}); end
    stall = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      vecs++; if (sram_raddr_a !== {6'd0, 6'd1, 6'd4, 6'd5}) begin errs++; $display("FAIL st_hold_addr[%0d] got=%h exp=%h", j, sram_raddr_a, {6'd0, 6'd1, 6'd4, 6'd5}); end
      vecs++; if ({win_valid, busy, sram_raddr_weight, sram_raddr_bias} !== {1'b1, 1'b1, 10'd9, 6'd5}) begin errs++; $display("FAIL st_hold_ctl[%0d] got=%b/%b/%0d/%0d exp=1/1/9/5", j, win_valid, busy, sram_raddr_weight, sram_raddr_bias); end
    end
    stall = 1'b0;
    tick();
    vecs++; if ({win_valid, sram_raddr_a} !== {1'b1, 6'd1, 6'd1, 6'd5, 6'd5}) begin errs++; $display("FAIL st_resume got=%b/%h exp=1/%h", win_valid, sram_raddr_a, {6'd1, 6'd1, 6'd5, 6'd5}); end
    tick();
    vecs++; if ({layer_done, win_valid} !== 2'b10) begin errs++; $display("FAIL st_done got=%b exp=10", {layer_done, win_valid}); end
    vecs++; if ({sram_raddr_weight, sram_raddr_bias} !== {10'd10, 6'd6}) begin errs++; $display("FAIL st_ptr got=%0d/%0d exp=10/6", sram_raddr_weight, sram_raddr_bias); end
    stall = 1'b1;
    tick();
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL st_done_nostall busy got=%0b exp=0", busy); end
    stall = 1'b0;
  endtask

  task automatic test_zero_dim();
    cfg(1'b0, 4'd3, 4'd3, 4'd0, 6'd6, 4'd3);
    start_layer();
    vecs++; if ({layer_done, win_valid, load_done, busy} !== 4'b1001) begin errs++; $display("FAIL zd_done got=%b exp=1001", {layer_done, win_valid, load_done, busy}); end
    vecs++; if (sram_raddr_weight !== 10'd10) begin errs++; $display("FAIL zd_weight got=%0d exp=10", sram_raddr_weight); end
    tick();
    vecs++; if ({busy, layer_done, win_valid} !== 3'b000) begin errs++; $display("FAIL zd_idle got=%b exp=000", {busy, layer_done, win_valid}); end
  endtask

  task automatic test_mid_reset();
    cfg(1'b0, 4'd4, 4'd4, 4'd2, 6'd6, 4'd0);
    start_layer();
    repeat (5) tick();
    vecs++; if (win_valid !== 1'b1) begin errs++; $display("FAIL mr_running got=%0b exp=1", win_valid); end
    rst_n = 1'b0; start = 1'b1;
    tick();
    vecs++; if ({busy, win_valid, load_done, layer_done} !== 4'b0000) begin errs++; $display("FAIL mr_flags got=%b exp=0000", {busy, win_valid, load_done, layer_done}); end
    vecs++; if ({sram_raddr_a, sram_raddr_b, sram_raddr_weight, sram_raddr_bias} !== 64'd0) begin errs++; $display("FAIL mr_outputs got=%h exp=0", {sram_raddr_a, sram_raddr_b, sram_raddr_weight, sram_raddr_bias}); end
    rst_n = 1'b1; start = 1'b0;
    tick();
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL mr_idle got=%0b exp=0", busy); end
    cfg(1'b0, 4'd2, 4'd2, 4'd1, 6'd6, 4'd1);
    start_layer();
    vecs++; if ({load_done, sram_raddr_weight} !== {1'b1, 10'd0}) begin errs++; $display("FAIL mr_load got=%0b/%0d exp=1/0", load_done, sram_raddr_weight); end
    tick();
    vecs++; if ({win_valid, sram_raddr_weight, sram_raddr_bias} !== {1'b1, 10'd0, 6'd0}) begin errs++; $display("FAIL mr_conv got=%0b/%0d/%0d exp=1/0/0", win_valid, sram_raddr_weight, sram_raddr_bias); end
    repeat (4) tick();
    vecs++; if ({layer_done, sram_raddr_weight, sram_raddr_bias} !== {1'b1, 10'd1, 6'd1}) begin errs++; $display("FAIL mr_done got=%0b/%0d/%0d exp=1/1/1", layer_done, sram_raddr_weight, sram_raddr_bias); end
    tick();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stall = 1'b0;
    cfg(1'b0, 4'd0, 4'd0, 4'd0, 6'd0, 4'd0);
    test_reset();
    test_load_sweep();
    test_group_a();
    test_group_b();
    test_stall();
    test_zero_dim();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
